// File: rtl/qos_traffic_ctrl.sv
// rtl/qos_traffic_ctrl.sv - QoS interconnect traffic generator and routing checker
module qos_traffic_ctrl #(
  parameter int BW            = 6,
  parameter int CLS_W         = 2,
  parameter int NUM_DEST      = 2,
  parameter int NUM_PKTS      = 8,
  parameter int CNT_W         = 8,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mode,
  input  logic [CLS_W-1:0]       class_sel,
  input  logic                   main_full,
  output logic                   main_wr,
  output logic [BW-1:0]          main_data,
  input  logic [NUM_DEST-1:0]    dest_empty,
  input  logic [NUM_DEST-1:0]    dest_error,
  input  logic [NUM_DEST*BW-1:0] dest_data,
  output logic [NUM_DEST-1:0]    dest_rd,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       sent_cnt,
  output logic [CNT_W-1:0]       recv_cnt,
  output logic                   route_err,
  output logic                   timeout
);
  localparam int PW     = BW - CLS_W;
  localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam logic [CNT_W-1:0]  NPKT = CNT_W'(NUM_PKTS);
  localparam logic [IDLE_W-1:0] TMO  = IDLE_W'(DRAIN_TIMEOUT);
  localparam logic [CLS_W-1:0]  LAST_CLS = CLS_W'(NUM_DEST - 1);

  logic [1:0]          state_q, state_d;
  logic [BW-1:0]       main_data_q, main_data_d;
  logic [CNT_W-1:0]    sent_cnt_q, sent_cnt_d;
  logic [CNT_W-1:0]    recv_cnt_q, recv_cnt_d;
  logic                route_err_q, route_err_d;
  logic                timeout_q, timeout_d;
  logic                mode_q, mode_d;
  logic [CLS_W-1:0]    cls_sel_q, cls_sel_d;
  logic [CLS_W-1:0]    rr_q, rr_d;
  logic [NUM_DEST-1:0] pop_q, pop_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;

  logic [CNT_W-1:0] pop_cnt;
  logic             bad_route;
  logic [CLS_W-1:0] rr_next;
  logic             unused_payload;

  assign unused_payload = ^dest_data;

  always_comb begin
    main_wr = (state_q == ST_SEND) & ~main_full & (sent_cnt_q < NPKT);
    dest_rd = '0;
    if (state_q == ST_SEND || state_q == ST_DRAIN) dest_rd = ~dest_empty & ~dest_error;

    // Checks act on the previous cycle's pops, when the popped data is valid.
    pop_cnt   = '0;
    bad_route = 1'b0;
    for (int i = 0; i < NUM_DEST; i++) begin
      pop_cnt = pop_cnt + CNT_W'(pop_q[i]);
      if (pop_q[i] && dest_data[i*BW+PW +: CLS_W] != CLS_W'(i)) bad_route = 1'b1;
    end
    rr_next = (rr_q == LAST_CLS) ? '0 : rr_q + 1'b1;

    state_d     = state_q;
    main_data_d = main_data_q;
    sent_cnt_d  = sent_cnt_q;
    recv_cnt_d  = recv_cnt_q + pop_cnt;
    route_err_d = route_err_q | bad_route;
    timeout_d   = timeout_q;
    mode_d      = mode_q;
    cls_sel_d   = cls_sel_q;
    rr_d        = rr_q;
    pop_d       = dest_rd;
    idle_d      = idle_q;

    case (state_q)
      ST_SEND: begin
        if (main_wr) begin
          sent_cnt_d  = sent_cnt_q + 1'b1;
          rr_d        = rr_next;
          main_data_d = {(mode_q ? cls_sel_q : rr_next), PW'(sent_cnt_d)};
          if (sent_cnt_d == NPKT) begin
            state_d = ST_DRAIN;
            idle_d  = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (|dest_rd)          idle_d = '0;
        else if (idle_q != TMO) idle_d = idle_q + 1'b1;
        if (recv_cnt_q == sent_cnt_q) begin
          state_d = ST_DONE;
        end else if (idle_q == TMO) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_d     = ST_SEND;
          sent_cnt_d  = '0;
          recv_cnt_d  = '0;
          route_err_d = 1'b0;
          timeout_d   = 1'b0;
          mode_d      = mode;
          cls_sel_d   = class_sel;
          rr_d        = '0;
          pop_d       = '0;
          idle_d      = '0;
          main_data_d = {(mode ? class_sel : {CLS_W{1'b0}}), {PW{1'b0}}};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      main_data_q <= '0;
      sent_cnt_q  <= '0;
      recv_cnt_q  <= '0;
      route_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      mode_q      <= 1'b0;
      cls_sel_q   <= '0;
      rr_q        <= '0;
      pop_q       <= '0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      sent_cnt_q  <= sent_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      route_err_q <= route_err_d;
      timeout_q   <= timeout_d;
      mode_q      <= mode_d;
      cls_sel_q   <= cls_sel_d;
      rr_q        <= rr_d;
      pop_q       <= pop_d;
      idle_q      <= idle_d;
    end
  end

  assign main_data = main_data_q;
  assign sent_cnt  = sent_cnt_q;
  assign recv_cnt  = recv_cnt_q;
  assign route_err = route_err_q;
  assign timeout   = timeout_q;
  assign busy      = (state_q == ST_SEND) | (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign pass      = done & ~route_err_q & ~timeout_q & (recv_cnt_q == NPKT);
endmodule
